// File: rtl/bcd_countdown_timer.sv
// Cascaded BCD countdown timer with IDLE/RUN/PAUSED/EXPIRED control and optional auto-reload.
// All outputs are registered and update one cycle after the causing input; there is no backpressure.
module bcd_countdown_timer #(
  parameter int NDIGITS     = 4,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 load,
  input  logic [4*NDIGITS-1:0] load_val,
  input  logic                 start,
  input  logic                 pause,
  output logic [4*NDIGITS-1:0] count,
  output logic                 running,
  output logic                 expired,
  output logic                 time_out
);

  localparam int W = 4 * NDIGITS;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t         state;
  logic [W-1:0]   reload;
  logic [W-1:0]   san_val;
  logic [W-1:0]   dec_val;
  logic           borrow;
  logic           count_is_one;
  logic           count_is_zero;

  // A digit borrows only while every digit below it is zero; zero digits wrap to 9.
  always_comb begin
    san_val = '0;
    dec_val = '0;
    borrow  = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      san_val[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
      if (borrow)
        dec_val[4*i +: 4] = (count[4*i +: 4] == 4'd0) ? 4'd9 : count[4*i +: 4] - 4'd1;
      else
        dec_val[4*i +: 4] = count[4*i +: 4];
      borrow = borrow & (count[4*i +: 4] == 4'd0);
    end
  end

  assign count_is_one  = (count == W'(1));
  assign count_is_zero = (count == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      reload   <= '0;
      running  <= 1'b0;
      expired  <= 1'b0;
      time_out <= 1'b0;
    end else if (load) begin
      state    <= IDLE;
      count    <= san_val;
      reload   <= san_val;
      running  <= 1'b0;
      expired  <= 1'b0;
      time_out <= 1'b0;
    end else begin
      time_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !pause && !count_is_zero) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (tick && count_is_one) begin
            time_out <= 1'b1;
            if (AUTO_RELOAD != 0) begin
              count <= reload;
              if (pause) begin
                state   <= PAUSED;
                running <= 1'b0;
              end
            end else begin
              count   <= '0;
              state   <= EXPIRED;
              running <= 1'b0;
              expired <= 1'b1;
            end
          end else begin
            // A pause on a tick cycle still takes that tick's decrement.
            if (tick)
              count <= dec_val;
            if (pause) begin
              state   <= PAUSED;
              running <= 1'b0;
            end
          end
        end
        PAUSED: begin
          if (start && !pause) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state <= EXPIRED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench: three instances (2 digits, 2 digits auto-reload, 4 digits) driven by shared controls.
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        rst, tick, load, start, pause;
  logic [7:0]  lv8;
  logic [15:0] lv16;
  logic [7:0]  c2, cr;
  logic [15:0] c4;
  logic        r2, e2, t2, rr, er, tr, r4, e4, t4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.NDIGITS(2), .AUTO_RELOAD(0)) u2 (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .load_val(lv8), .start(start),
    .pause(pause), .count(c2), .running(r2), .expired(e2), .time_out(t2));

  bcd_countdown_timer #(.NDIGITS(2), .AUTO_RELOAD(1)) ur (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .load_val(lv8), .start(start),
    .pause(pause), .count(cr), .running(rr), .expired(er), .time_out(tr));

  bcd_countdown_timer #(.NDIGITS(4), .AUTO_RELOAD(0)) u4 (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .load_val(lv16), .start(start),
    .pause(pause), .count(c4), .running(r4), .expired(e4), .time_out(t4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v8, input logic [15:0] v16);
    lv8 = v8; lv16 = v16; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 1'b1; lv8 = 8'h55; lv16 = 16'h5555; start = 1'b1; tick = 1'b1;
    step(); step();
    load = 1'b0; start = 1'b0; tick = 1'b0;
    n_checks++; if (c2 !== 8'h00) begin n_fail++; $display("FAIL reset_count: got %h want 00", c2); end
    n_checks++; if ({r2, e2, t2} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {r2, e2, t2}); end
    n_checks++; if (c4 !== 16'h0000) begin n_fail++; $display("FAIL reset_count4: got %h want 0000", c4); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_borrow_expiry();
    do_load(8'h10, 16'h0000);
    n_checks++; if (c2 !== 8'h10 || r2 !== 1'b0) begin n_fail++; $display("FAIL load_10: got %h run %b want 10 run 0", c2, r2); end
    do_start();
    n_checks++; if (r2 !== 1'b1) begin n_fail++; $display("FAIL start_run: got %b want 1", r2); end
    do_ticks(1);
    n_checks++; if (c2 !== 8'h09) begin n_fail++; $display("FAIL borrow: got %h want 09", c2); end
    do_ticks(8);
    n_checks++; if (c2 !== 8'h01 || t2 !== 1'b0) begin n_fail++; $display("FAIL pre_expiry: got %h to %b want 01 to 0", c2, t2); end
    do_ticks(1);
    n_checks++; if (c2 !== 8'h00 || t2 !== 1'b1 || e2 !== 1'b1 || r2 !== 1'b0) begin
      n_fail++; $display("FAIL expiry: got %h to %b exp %b run %b want 00 1 1 0", c2, t2, e2, r2); end
    n_checks++; if (cr !== 8'h10 || tr !== 1'b1 || rr !== 1'b1) begin
      n_fail++; $display("FAIL reload_10: got %h to %b run %b want 10 1 1", cr, tr, rr); end
    step();
    n_checks++; if (t2 !== 1'b0 || e2 !== 1'b1) begin n_fail++; $display("FAIL pulse_width: got to %b exp %b want 0 1", t2, e2); end
    start = 1'b1; tick = 1'b1; step(); start = 1'b0; tick = 1'b0;
    n_checks++; if (e2 !== 1'b1 || r2 !== 1'b0 || c2 !== 8'h00 || t2 !== 1'b0) begin
      n_fail++; $display("FAIL expired_hold: got exp %b run %b cnt %h to %b want 1 0 00 0", e2, r2, c2, t2); end
  endtask

  task automatic test_sanitise();
    lv8 = 8'hAF; lv16 = 16'hFA3C; load = 1'b1; start = 1'b1;
    step();
    load = 1'b0; start = 1'b0;
    n_checks++; if (c2 !== 8'h99 || e2 !== 1'b0 || r2 !== 1'b0) begin
      n_fail++; $display("FAIL sanitise2: got %h exp %b run %b want 99 0 0", c2, e2, r2); end
    n_checks++; if (c4 !== 16'h9939) begin n_fail++; $display("FAIL sanitise4: got %h want 9939", c4); end
    do_start();
    do_ticks(1);
    n_checks++; if (c2 !== 8'h98) begin n_fail++; $display("FAIL sanitise_tick: got %h want 98", c2); end
  endtask

  task automatic test_pause();
    do_load(8'h05, 16'h0000);
    do_start();
    do_ticks(2);
    n_checks++; if (c2 !== 8'h03) begin n_fail++; $display("FAIL pause_pre: got %h want 03", c2); end
    pause = 1'b1; step(); pause = 1'b0;
    do_ticks(3);
    n_checks++; if (c2 !== 8'h03 || r2 !== 1'b0) begin n_fail++; $display("FAIL pause_hold: got %h run %b want 03 0", c2, r2); end
    start = 1'b1; pause = 1'b1; step(); start = 1'b0; pause = 1'b0;
    n_checks++; if (r2 !== 1'b0) begin n_fail++; $display("FAIL pause_wins: got run %b want 0", r2); end
    do_start();
    do_ticks(1);
    n_checks++; if (c2 !== 8'h02 || r2 !== 1'b1) begin n_fail++; $display("FAIL resume: got %h run %b want 02 1", c2, r2); end
    tick = 1'b1; pause = 1'b1; step(); tick = 1'b0; pause = 1'b0;
    n_checks++; if (c2 !== 8'h01 || r2 !== 1'b0) begin n_fail++; $display("FAIL tick_pause: got %h run %b want 01 0", c2, r2); end
  endtask

  task automatic test_auto_reload();
    do_load(8'h03, 16'h0000);
    do_start();
    do_ticks(2);
    n_checks++; if (cr !== 8'h01 || tr !== 1'b0) begin n_fail++; $display("FAIL ar_pre: got %h to %b want 01 0", cr, tr); end
    do_ticks(1);
    n_checks++; if (tr !== 1'b1 || cr !== 8'h03 || rr !== 1'b1 || er !== 1'b0) begin
      n_fail++; $display("FAIL ar_first: got to %b cnt %h run %b exp %b want 1 03 1 0", tr, cr, rr, er); end
    do_ticks(1);
    n_checks++; if (tr !== 1'b0 || cr !== 8'h02) begin n_fail++; $display("FAIL ar_mid: got to %b cnt %h want 0 02", tr, cr); end
    do_ticks(2);
    n_checks++; if (tr !== 1'b1 || cr !== 8'h03 || rr !== 1'b1) begin
      n_fail++; $display("FAIL ar_second: got to %b cnt %h run %b want 1 03 1", tr, cr, rr); end
    do_load(8'h07, 16'h0000);
    n_checks++; if (tr !== 1'b0 || cr !== 8'h07 || rr !== 1'b0) begin
      n_fail++; $display("FAIL ar_load: got to %b cnt %h run %b want 0 07 0", tr, cr, rr); end
  endtask

  task automatic test_start_zero();
    rst = 1'b0; step(); rst = 1'b1;
    do_start();
    n_checks++; if (r2 !== 1'b0 || c2 !== 8'h00) begin n_fail++; $display("FAIL start_zero: got run %b cnt %h want 0 00", r2, c2); end
    do_ticks(1);
    n_checks++; if (c2 !== 8'h00 || t2 !== 1'b0 || e2 !== 1'b0) begin
      n_fail++; $display("FAIL zero_tick: got %h to %b exp %b want 00 0 0", c2, t2, e2); end
  endtask

  task automatic test_reset_midcount();
    do_load(8'h01, 16'h1000);
    do_start();
    do_ticks(1);
    n_checks++; if (c4 !== 16'h0999) begin n_fail++; $display("FAIL mid_borrow4: got %h want 0999", c4); end
    tick = 1'b1; rst = 1'b0; step(); rst = 1'b1; tick = 1'b0;
    n_checks++; if (c4 !== 16'h0000 || t4 !== 1'b0 || r4 !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset4: got %h to %b run %b want 0000 0 0", c4, t4, r4); end
    n_checks++; if (t2 !== 1'b0 || e2 !== 1'b0 || r2 !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset2: got to %b exp %b run %b want 0 0 0", t2, e2, r2); end
    do_load(8'h02, 16'h0002);
    do_start();
    do_ticks(1);
    n_checks++; if (c4 !== 16'h0001 || r4 !== 1'b1 || t4 !== 1'b0) begin
      n_fail++; $display("FAIL restart: got %h run %b to %b want 0001 1 0", c4, r4, t4); end
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    lv8 = 8'h00; lv16 = 16'h0000;
    test_reset();
    test_borrow_expiry();
    test_sanitise();
    test_pause();
    test_auto_reload();
    test_start_zero();
    test_reset_midcount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 SHALL have parameter NDIGITS, default 4, number of cascaded BCD digits (1..8).
REQ-002 SHALL have parameter AUTO_RELOAD, default 0, 1 = reload on expiry and keep running.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port tick  input  1  one-cycle count enable (e.g. tenth-second strobe).
REQ-006 SHALL have port load  input  1  reconfigure: capture load_val.
REQ-007 SHALL have port load_val  input  4*NDIGITS  BCD preset from toggle switches; digit 0 in [3:0] is least significant.
REQ-008 SHALL have port start  input  1  start/resume pulse.
REQ-009 SHALL have port pause  input  1  pause pulse.
REQ-010 SHALL have port count  output  4*NDIGITS  current BCD value, registered.
REQ-011 SHALL have port running  output  1  high in RUN state.
REQ-012 SHALL have port expired  output  1  high in EXPIRED state.
REQ-013 SHALL have port time_out  output  1  one-cycle pulse on each expiry.

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSED, EXPIRED; all outputs registered.
REQ-015 SHALL give load priority over all other inputs: count <= sanitised load_val, reload register <= same value, state <= IDLE, time_out <= 0.
REQ-016 SHALL sanitise each loaded digit: values 10..15 saturate to 9.
REQ-017 SHALL go IDLE->RUN on start when count != 0; start with count == 0 leaves state IDLE.
REQ-018 SHALL go RUN->PAUSED on pause; PAUSED->RUN on start without pause; pause wins when start and pause coincide, in every state.
REQ-019 SHALL ignore tick outside RUN; count holds.
REQ-020 SHALL, in RUN on tick, decrement count by 1 as BCD: digit i decrements when all lower digits were 0; a digit at 0 that decrements wraps to 9.
REQ-021 SHALL detect expiry when tick occurs in RUN with count == 1 (digit 0 = 1, others 0).
REQ-022 SHALL, on expiry with AUTO_RELOAD = 0: count <= 0, state <= EXPIRED, time_out = 1 for exactly that one cycle.
REQ-023 SHALL, on expiry with AUTO_RELOAD = 1: count <= reload register, state stays RUN, time_out = 1 for one cycle.
REQ-024 SHALL leave EXPIRED only via load (to IDLE) or reset; start, pause and tick are ignored there.
REQ-025 SHALL drive time_out low in every cycle other than an expiry cycle, including load cycles.
REQ-026 SHALL latch pause arriving on a tick cycle in RUN only after applying that tick's decrement, with both effects in the same edge.
REQ-027 SHALL hold count unchanged on any cycle without a qualifying tick or load.

Reset
REQ-028 SHALL, when rst = 0 at a clock edge, set count = 0, reload register = 0, state = IDLE, running = 0, expired = 0, time_out = 0, overriding load, start, pause and tick.
REQ-029 SHALL restart cleanly after reset asserted mid-count; no residual time_out pulse.

Verification (NDIGITS = 2 unless stated)
REQ-030 SHALL pass: load 0x10, start, 1 tick -> count 0x09 (digit borrow); 9 more ticks -> count 0x00, time_out high 1 cycle, expired = 1.
REQ-031 SHALL pass: load 0xAF -> count 0x99; start, tick -> 0x98.
REQ-032 SHALL pass: load 0x05, start, 2 ticks, pause, 3 ticks -> count 0x03 held; start, 1 tick -> 0x02.
REQ-033 SHALL pass: AUTO_RELOAD = 1, load 0x03, start, 3 ticks -> time_out pulse, count 0x03, running = 1; 3 more ticks -> second pulse.
REQ-034 SHALL pass: start with count 0x00 after reset -> state IDLE, running = 0; tick -> no change.
REQ-035 SHALL pass: NDIGITS = 4, load 0x1000, start, rst = 0 after 1 tick (count 0x0999) -> next edge count 0x0000, time_out 0, running 0.
